uart_loopback_fifo: RTL and testbench

Parametrised loopback engine between the rx and tx ready/valid ports of `uart_core`. Received characters are buffered in a FIFO and transformed according to a runtime mode: plain echo, case swap, or uppercase. A line mode holds characters until carriage return and then drains them as a burst. It replaces the single-character loopback register in FPGA top levels, and exposes FIFO status and a sticky match flag for LEDs.

---
 rtl/uart_loopback_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_loopback_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_fifo.sv
// Loopback buffer between uart_core rx and tx: transforms characters on push, buffers them in a FWFT FIFO, optionally holds a line until EOL.
// PASS latency 1 cycle push-to-tx_valid; rx_ready drops when full or draining a line, tx_valid holds until tx_ready.
module uart_loopback_fifo #(
  parameter int         DATA_WIDTH = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] MATCH_CHAR = 8'd65,
  parameter logic [7:0] EOL_CHAR   = 8'h0D
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          match_seen
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [1:0]    MODE_LINE = 2'b11;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          active_mode_q, active_mode_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                match_q, match_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                push, pop, mode_load, is_eol;
  logic [DATA_WIDTH-1:0] push_dat;

  function automatic logic [DATA_WIDTH-1:0] xform(input logic [1:0] m,
                                                  input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    logic                  is_up, is_lo;
    r     = d;
    is_up = (d[7:0] >= 8'h41) && (d[7:0] <= 8'h5A);
    is_lo = (d[7:0] >= 8'h61) && (d[7:0] <= 8'h7A);
    case (m)
      2'b01, 2'b11: begin
        if (is_up)      r[7:0] = d[7:0] + 8'd32;
        else if (is_lo) r[7:0] = d[7:0] - 8'd32;
      end
      2'b10: begin
        if (is_lo) r[7:0] = d[7:0] - 8'd32;
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign push      = rx_valid && rx_ready;
  assign pop       = tx_valid && tx_ready;
  assign push_dat  = xform(active_mode_q, rx_data);
  assign is_eol    = (rx_data[7:0] == EOL_CHAR);
  // Mode switches only at a clean boundary so queued characters keep their transform.
  assign mode_load = (count_q == '0) && (state_q != DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PASS;
      active_mode_q <= 2'b00;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      match_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_mode_q <= active_mode_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      match_q       <= match_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_dat;
  end

  always_comb begin
    active_mode_d = mode_load ? mode : active_mode_q;
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    match_d       = match_q || (push && (rx_data[7:0] == MATCH_CHAR));
    count_d       = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PASS: begin
        if (mode_load && (mode == MODE_LINE)) state_d = FILL;
      end
      FILL: begin
        if (push && (is_eol || (count_q == LAST_CNT))) state_d = DRAIN;
        else if (mode_load && (mode != MODE_LINE))     state_d = PASS;
      end
      DRAIN: begin
        if (pop && (count_q == ONE_CNT)) state_d = FILL;
      end
      default: state_d = PASS;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        PASS: begin
          rx_ready = (count_q != FULL_CNT);
          tx_valid = (count_q != '0);
        end
        FILL: begin
          rx_ready = (count_q != FULL_CNT);
          tx_valid = 1'b0;
        end
        DRAIN: begin
          rx_ready = 1'b0;
          tx_valid = (count_q != '0);
        end
        default: begin
          rx_ready = 1'b0;
          tx_valid = 1'b0;
        end
      endcase
    end
  end

  assign tx_data    = mem[rd_ptr_q];
  assign fifo_count = count_q;
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign match_seen = match_q;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed bench for uart_loopback_fifo with default parameters (8-bit, depth 16).
module tb_uart_loopback_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       match_seen;

  int total = 0;
  int bad   = 0;
  int acc;

  always #5 clk = ~clk;

  uart_loopback_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .match_seen (match_seen)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one character in a pass-through mode with tx_ready high and expect it back next cycle.
  task automatic push_echo(input logic [7:0] c, input logic [7:0] e, input string tag);
    rx_data  = c;
    rx_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(rx_ready), 32'd1);
    tick;
    rx_valid = 1'b0;
    chk({tag, "_vld"}, 32'(tx_valid), 32'd1);
    chk({tag, "_dat"}, 32'(tx_data), 32'(e));
    chk({tag, "_cnt1"}, 32'(fifo_count), 32'd1);
    tick;
    chk({tag, "_cnt0"}, 32'(fifo_count), 32'd0);
    chk({tag, "_idle"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic push_one(input logic [7:0] c);
    rx_data  = c;
    rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    tick;
    tick;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_match", 32'(match_seen), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    // Echo
    tx_ready = 1'b1;
    push_echo("a", "a", "echo_a");
    push_echo("Z", "Z", "echo_Z");
    push_echo("5", "5", "echo_5");
    chk("echo_nomatch", 32'(match_seen), 32'd0);

    // Case swap and match, then uppercase
    mode = 2'b01;
    tick;
    push_echo("A", "a", "swap_A");
    chk("match_set", 32'(match_seen), 32'd1);
    push_echo("b", "B", "swap_b");
    push_echo("@", "@", "swap_at");
    chk("match_sticky", 32'(match_seen), 32'd1);
    mode = 2'b10;
    tick;
    push_echo("q", "Q", "up_q");
    push_echo("Q", "Q", "up_Q");

    // Backpressure: offer 20, expect 16 accepted, drained in order across pointer wrap
    mode = 2'b00;
    tick;
    tx_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      rx_data  = 8'h30 + 8'(i);
      rx_valid = 1'b1;
      if (rx_ready) acc++;
      tick;
    end
    rx_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd16);
    chk("bp_full", 32'(fifo_full), 32'd1);
    chk("bp_count", 32'(fifo_count), 32'd16);
    chk("bp_rx_ready", 32'(rx_ready), 32'd0);
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h7E;
    #1;
    chk("bp_no_bypass", 32'(rx_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("bp_drain_vld", 32'(tx_valid), 32'd1);
      chk("bp_drain_dat", 32'(tx_data), 32'h30 + 32'(i));
      tick;
      rx_valid = 1'b0;
    end
    chk("bp_empty", 32'(fifo_empty), 32'd1);
    chk("bp_after_vld", 32'(tx_valid), 32'd0);

    // Line mode
    mode = 2'b11;
    tick;
    push_one("h");
    chk("line_hold1", 32'(tx_valid), 32'd0);
    push_one("i");
    chk("line_hold2", 32'(tx_valid), 32'd0);
    chk("line_cnt2", 32'(fifo_count), 32'd2);
    rx_data = 8'h0D; rx_valid = 1'b1;
    #1;
    chk("line_hold_eol", 32'(tx_valid), 32'd0);
    tick;
    rx_valid = 1'b0;
    chk("line_d0_vld", 32'(tx_valid), 32'd1);
    chk("line_d0_dat", 32'(tx_data), 32'h48);
    chk("line_d0_rdy", 32'(rx_ready), 32'd0);
    tick;
    chk("line_d1_dat", 32'(tx_data), 32'h49);
    chk("line_d1_rdy", 32'(rx_ready), 32'd0);
    tick;
    chk("line_d2_vld", 32'(tx_valid), 32'd1);
    chk("line_d2_dat", 32'(tx_data), 32'h0D);
    chk("line_d2_rdy", 32'(rx_ready), 32'd0);
    tick;
    chk("line_fill_rdy", 32'(rx_ready), 32'd1);
    chk("line_fill_vld", 32'(tx_valid), 32'd0);
    chk("line_fill_empty", 32'(fifo_empty), 32'd1);

    // Auto-flush on 16 characters without EOL
    for (int i = 0; i < 16; i++) begin
      chk("af_hold_vld", 32'(tx_valid), 32'd0);
      push_one(8'h61 + 8'(i));
    end
    chk("af_vld", 32'(tx_valid), 32'd1);
    chk("af_full", 32'(fifo_full), 32'd1);
    chk("af_rdy", 32'(rx_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("af_drain_dat", 32'(tx_data), 32'h41 + 32'(i));
      tick;
    end
    chk("af_fill_rdy", 32'(rx_ready), 32'd1);
    chk("af_fill_empty", 32'(fifo_empty), 32'd1);

    // Mode change deferred while characters are queued
    mode = 2'b00;
    tick;
    tx_ready = 1'b0;
    push_one("x");
    push_one("y");
    push_one("z");
    mode = 2'b11;
    tick;
    chk("mc_still_pass_vld", 32'(tx_valid), 32'd1);
    push_one("d");
    chk("mc_cnt4", 32'(fifo_count), 32'd4);
    tx_ready = 1'b1;
    #1;
    chk("mc_q0", 32'(tx_data), 32'h78);
    tick;
    chk("mc_q1", 32'(tx_data), 32'h79);
    tick;
    chk("mc_q2", 32'(tx_data), 32'h7A);
    tick;
    chk("mc_q3_old_mode", 32'(tx_data), 32'h64);
    tick;
    chk("mc_empty", 32'(fifo_empty), 32'd1);
    tick;
    push_one("e");
    chk("mc_fill_vld", 32'(tx_valid), 32'd0);
    chk("mc_fill_cnt", 32'(fifo_count), 32'd1);

    // Reset in the middle of a drain
    push_one("f");
    tx_ready = 1'b0;
    push_one(8'h0D);
    chk("rd_drain_vld", 32'(tx_valid), 32'd1);
    chk("rd_drain_dat", 32'(tx_data), 32'h45);
    tx_ready = 1'b1;
    tick;
    chk("rd_drain_dat2", 32'(tx_data), 32'h46);
    rst  = 1'b1;
    mode = 2'b00;
    tick;
    chk("rd_count", 32'(fifo_count), 32'd0);
    chk("rd_tx_valid", 32'(tx_valid), 32'd0);
    chk("rd_match", 32'(match_seen), 32'd0);
    chk("rd_rx_ready", 32'(rx_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rd_rel_rdy", 32'(rx_ready), 32'd1);
    push_echo("k", "k", "rd_pass_k");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
